// File: rtl/attendance_tracker_pkg.sv
// Shared definitions for the attendance tracker: state encoding and timer sizing.
package attendance_tracker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  // Timer must hold 0..cycles; a disabled timeout still needs one bit.
  function automatic int unsigned timer_width(input int unsigned cycles);
    if (cycles == 0) return 1;
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/attendance_tracker_popcount_n.sv
// Combinational population count of a WIDTH-bit vector.
module popcount_n #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0]               bits_i,
  output logic [$clog2(WIDTH+1)-1:0]     count_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  always_comb begin
    count_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      count_o = count_o + CW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/attendance_tracker.sv
// Arrival barrier: sticky per-member mask, running count, completion,
// round timeout and duplicate-arrival detection.
module attendance_tracker
  import attendance_tracker_pkg::*;
#(
  parameter int unsigned N_MEMBERS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter bit          AUTO_REARM     = 1'b1,
  parameter int unsigned CNT_W          = $clog2(N_MEMBERS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic [N_MEMBERS-1:0] arrive,
  input  logic                 clear,
  output logic [N_MEMBERS-1:0] arrived_mask,
  output logic [CNT_W-1:0]     arrived_count,
  output logic                 all_in,
  output logic                 timeout,
  output logic                 dup_err,
  output logic                 busy
);

  localparam int unsigned          TMR_W   = timer_width(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0]     TMR_MAX = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [N_MEMBERS-1:0] FULL    = '1;

  state_e               state_q;
  logic [N_MEMBERS-1:0] mask_q;
  logic [N_MEMBERS-1:0] mask_d;
  logic [N_MEMBERS-1:0] nxt;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     count_d;
  logic [TMR_W-1:0]     timer_q;
  logic                 all_in_q;
  logic                 timeout_q;
  logic                 dup_q;
  logic                 busy_q;

  assign nxt = mask_q | arrive;

  // Next mask value; the count is registered from its popcount so both move together.
  always_comb begin
    mask_d = mask_q;
    if (clear) begin
      mask_d = '0;
    end else begin
      case (state_q)
        ST_IDLE:    mask_d = arrive;
        ST_COLLECT: mask_d = nxt;
        ST_DONE:    mask_d = AUTO_REARM ? '0 : mask_q;
        ST_TIMEOUT: mask_d = mask_q;
        default:    mask_d = '0;
      endcase
    end
  end

  popcount_n #(
    .WIDTH (N_MEMBERS)
  ) u_popcount (
    .bits_i  (mask_d),
    .count_o (count_d)
  );

  // Round FSM with registered flags.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      mask_q    <= '0;
      count_q   <= '0;
      timer_q   <= '0;
      all_in_q  <= 1'b0;
      timeout_q <= 1'b0;
      dup_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      mask_q  <= mask_d;
      count_q <= count_d;
      dup_q   <= 1'b0;
      if (clear) begin
        state_q   <= ST_IDLE;
        timer_q   <= '0;
        all_in_q  <= 1'b0;
        timeout_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (|arrive) begin
              timer_q <= TMR_W'(1);
              if (arrive == FULL) begin
                state_q  <= ST_DONE;
                all_in_q <= 1'b1;
              end else begin
                state_q <= ST_COLLECT;
                busy_q  <= 1'b1;
              end
            end
          end
          ST_COLLECT: begin
            dup_q <= |(arrive & mask_q);
            if (nxt == FULL) begin
              state_q  <= ST_DONE;
              all_in_q <= 1'b1;
              busy_q   <= 1'b0;
            end else if ((TIMEOUT_CYCLES != 0) && (timer_q == TMR_MAX)) begin
              state_q   <= ST_TIMEOUT;
              timeout_q <= 1'b1;
              busy_q    <= 1'b0;
            end else if ((TIMEOUT_CYCLES != 0) && (timer_q < TMR_MAX)) begin
              timer_q <= timer_q + TMR_W'(1);
            end
          end
          ST_DONE: begin
            if (AUTO_REARM) begin
              state_q  <= ST_IDLE;
              all_in_q <= 1'b0;
              timer_q  <= '0;
            end
          end
          ST_TIMEOUT: begin
            state_q <= ST_TIMEOUT;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign arrived_mask  = mask_q;
  assign arrived_count = count_q;
  assign all_in        = all_in_q;
  assign timeout       = timeout_q;
  assign dup_err       = dup_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_attendance_tracker.sv
// Directed bench for attendance_tracker: defaults, short timeout, and 8-member hold variant.
module tb_attendance_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: defaults (N=4, T=16, auto re-arm)
  logic       rst_a, clr_a, all_a, to_a, dup_a, busy_a;
  logic [3:0] arr_a, mask_a;
  logic [2:0] cnt_a;
  // DUT B: N=4, T=4
  logic       rst_b, clr_b, all_b, to_b, dup_b, busy_b;
  logic [3:0] arr_b, mask_b;
  logic [2:0] cnt_b;
  // DUT C: N=8, AUTO_REARM=0
  logic       rst_c, clr_c, all_c, to_c, dup_c, busy_c;
  logic [7:0] arr_c, mask_c;
  logic [3:0] cnt_c;

  attendance_tracker u_a (
    .clk(clk), .rst_in(rst_a), .arrive(arr_a), .clear(clr_a),
    .arrived_mask(mask_a), .arrived_count(cnt_a), .all_in(all_a),
    .timeout(to_a), .dup_err(dup_a), .busy(busy_a));

  attendance_tracker #(.N_MEMBERS(4), .TIMEOUT_CYCLES(4)) u_b (
    .clk(clk), .rst_in(rst_b), .arrive(arr_b), .clear(clr_b),
    .arrived_mask(mask_b), .arrived_count(cnt_b), .all_in(all_b),
    .timeout(to_b), .dup_err(dup_b), .busy(busy_b));

  attendance_tracker #(.N_MEMBERS(8), .AUTO_REARM(1'b0)) u_c (
    .clk(clk), .rst_in(rst_c), .arrive(arr_c), .clear(clr_c),
    .arrived_mask(mask_c), .arrived_count(cnt_c), .all_in(all_c),
    .timeout(to_c), .dup_err(dup_c), .busy(busy_c));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] arr;
    logic       clr;
    logic [3:0] m;
    logic [2:0] c;
    logic       a, t, d, b;
  } vec_t;

  vec_t vecs [21];

  function automatic vec_t mk(input logic [3:0] arr, input logic clr, input logic [3:0] m,
                              input logic [2:0] c, input logic a, input logic t,
                              input logic d, input logic b);
    vec_t v;
    v.arr = arr; v.clr = clr; v.m = m; v.c = c; v.a = a; v.t = t; v.d = d; v.b = b;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Packed views: {mask, count, all_in, timeout, dup_err, busy}
  function automatic logic [10:0] pk_a();
    return {mask_a, cnt_a, all_a, to_a, dup_a, busy_a};
  endfunction
  function automatic logic [10:0] pk_b();
    return {mask_b, cnt_b, all_b, to_b, dup_b, busy_b};
  endfunction
  function automatic logic [15:0] pk_c();
    return {mask_c, cnt_c, all_c, to_c, dup_c, busy_c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Defaults: one member per cycle
    vecs[0]  = mk(4'b0001, 0, 4'b0001, 3'd1, 0, 0, 0, 1);
    vecs[1]  = mk(4'b0010, 0, 4'b0011, 3'd2, 0, 0, 0, 1);
    vecs[2]  = mk(4'b0100, 0, 4'b0111, 3'd3, 0, 0, 0, 1);
    vecs[3]  = mk(4'b1000, 0, 4'b1111, 3'd4, 1, 0, 0, 0);
    vecs[4]  = mk(4'b0000, 0, 4'b0000, 3'd0, 0, 0, 0, 0);
    vecs[5]  = mk(4'b0000, 0, 4'b0000, 3'd0, 0, 0, 0, 0);
    // Batched arrivals, then all at once from IDLE
    vecs[6]  = mk(4'b0011, 0, 4'b0011, 3'd2, 0, 0, 0, 1);
    vecs[7]  = mk(4'b0100, 0, 4'b0111, 3'd3, 0, 0, 0, 1);
    vecs[8]  = mk(4'b1000, 0, 4'b1111, 3'd4, 1, 0, 0, 0);
    vecs[9]  = mk(4'b0000, 0, 4'b0000, 3'd0, 0, 0, 0, 0);
    vecs[10] = mk(4'b1111, 0, 4'b1111, 3'd4, 1, 0, 0, 0);
    vecs[11] = mk(4'b0000, 0, 4'b0000, 3'd0, 0, 0, 0, 0);
    // Duplicate arrival
    vecs[12] = mk(4'b0001, 0, 4'b0001, 3'd1, 0, 0, 0, 1);
    vecs[13] = mk(4'b0011, 0, 4'b0011, 3'd2, 0, 0, 1, 1);
    vecs[14] = mk(4'b1100, 0, 4'b1111, 3'd4, 1, 0, 0, 0);
    vecs[15] = mk(4'b0000, 0, 4'b0000, 3'd0, 0, 0, 0, 0);
    // Clear with a completing arrive drops it
    vecs[16] = mk(4'b0111, 0, 4'b0111, 3'd3, 0, 0, 0, 1);
    vecs[17] = mk(4'b1000, 1, 4'b0000, 3'd0, 0, 0, 0, 0);
    vecs[18] = mk(4'b0000, 0, 4'b0000, 3'd0, 0, 0, 0, 0);
    // Arrival during the DONE cycle is ignored (no dup_err)
    vecs[19] = mk(4'b1111, 0, 4'b1111, 3'd4, 1, 0, 0, 0);
    vecs[20] = mk(4'b0001, 0, 4'b0000, 3'd0, 0, 0, 0, 0);

    rst_a = 1; rst_b = 1; rst_c = 1;
    clr_a = 0; clr_b = 0; clr_c = 0;
    arr_a = '0; arr_b = '0; arr_c = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 0; rst_b = 0; rst_c = 0;
    check("reset_a", 64'(pk_a()), 64'(0));
    check("reset_b", 64'(pk_b()), 64'(0));
    check("reset_c", 64'(pk_c()), 64'(0));

    for (int i = 0; i < 21; i++) begin
      arr_a = vecs[i].arr;
      clr_a = vecs[i].clr;
      tick();
      check($sformatf("vec_a[%0d]", i), 64'(pk_a()),
            64'({vecs[i].m, vecs[i].c, vecs[i].a, vecs[i].t, vecs[i].d, vecs[i].b}));
    end
    arr_a = '0; clr_a = 0;

    // Asynchronous reset mid-round
    arr_a = 4'b0110;
    tick();
    arr_a = '0;
    check("pre_rst_mid", 64'(pk_a()), 64'({4'b0110, 3'd2, 4'b0001}));
    #2 rst_a = 1;
    #1 check("async_rst", 64'(pk_a()), 64'(0));
    #2 rst_a = 0;
    tick();
    check("post_rst_idle", 64'(pk_a()), 64'(0));

    // Timeout after 4 further edges, mask frozen
    arr_b = 4'b0101;
    tick();
    arr_b = '0;
    check("to_start", 64'(pk_b()), 64'({4'b0101, 3'd2, 4'b0001}));
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("to_wait[%0d]", k), 64'(pk_b()), 64'({4'b0101, 3'd2, 4'b0001}));
    end
    tick();
    check("to_fire", 64'(pk_b()), 64'({4'b0101, 3'd2, 4'b0100}));
    arr_b = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("to_ignore[%0d]", k), 64'(pk_b()), 64'({4'b0101, 3'd2, 4'b0100}));
    end
    arr_b = '0;
    clr_b = 1;
    tick();
    clr_b = 0;
    check("to_clear", 64'(pk_b()), 64'(0));

    // Completion on the same edge the timer expires beats timeout
    arr_b = 4'b0001;
    tick();
    arr_b = '0;
    repeat (3) tick();
    check("race_pre", 64'(pk_b()), 64'({4'b0001, 3'd1, 4'b0001}));
    arr_b = 4'b1110;
    tick();
    arr_b = '0;
    check("race_done", 64'(pk_b()), 64'({4'b1111, 3'd4, 4'b1000}));
    tick();
    check("race_rearm", 64'(pk_b()), 64'(0));

    // Held completion with AUTO_REARM=0
    arr_c = 8'hFF;
    tick();
    check("hold_enter", 64'(pk_c()), 64'({8'hFF, 4'd8, 4'b1000}));
    arr_c = 8'h01;
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("hold[%0d]", k), 64'(pk_c()), 64'({8'hFF, 4'd8, 4'b1000}));
    end
    arr_c = '0;
    clr_c = 1;
    tick();
    clr_c = 0;
    check("hold_clear", 64'(pk_c()), 64'(0));
    arr_c = 8'h01;
    tick();
    arr_c = '0;
    check("hold_rearmed", 64'(pk_c()), 64'({8'h01, 4'd1, 4'b0001}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
